uart_tx: RTL and testbench
==========================

// Module: uart_tx
// PURPOSE
//  UART transmitter; the opposite end of the UART RX path. Accepts a parallel word with a
//  valid strobe and serializes a frame: start(0), data LSB-first, optional parity, stop(1).
//  clk is the TX baud clock: exactly one serial bit per clk cycle, with no oversampling.
//  Sits between the system controller / TX FIFO reader and the tx_out pad.
// PARAMETERS
//  DATA_WIDTH  8  payload bits per frame (>=1)
// PORTS
//  clk         in   1           TX baud clock; all state on rising edge
//  reset_n     in   1           asynchronous, active-low reset
//  p_data      in   DATA_WIDTH  parallel payload; sampled only on accept
//  data_valid  in   1           payload strobe; accepted when not busy, or on last stop cycle
//  par_en      in   1           1 = insert parity bit; sampled on accept
//  par_typ     in   1           0 = even, 1 = odd; sampled on accept
//  tx_out      out  1           serial line, registered, idle high
//  busy        out  1           high while a frame is on tx_out, registered
// BEHAVIOUR
//  Reset (async, any time incl. mid-frame): state=IDLE, tx_out=1, busy=0, shift reg=0,
//   bit counter=0. The partial frame is abandoned and not resumed.
//  Accept: rising edge with data_valid=1 in IDLE, or in STOP (back-to-back). At accept, latch
//   p_data, par_en and par_typ, and compute the parity bit: ^p_data XOR par_typ.
//  Latency: the start bit appears on tx_out in the cycle right after the accept edge.
//   busy rises on the same edge.
//  FSM states (registered outputs show the bit of the current state):
//   IDLE   : tx_out=1, busy=0. data_valid -> START, else stay in IDLE.
//   START  : tx_out=0 for 1 cycle -> DATA.
//   DATA   : tx_out=shift[0], shifts right each cycle. Bit counter runs 0..DATA_WIDTH-1.
//            At count DATA_WIDTH-1: -> PARITY if latched par_en, else -> STOP.
//   PARITY : tx_out=latched parity bit for 1 cycle -> STOP.
//   STOP   : tx_out=1 for 1 cycle. -> START (new word accepted) if data_valid, else -> IDLE.
//            busy stays high across a back-to-back transition.
//  Frame length: DATA_WIDTH+2 cycles, or +3 with parity. 8N1=10 cycles, 8E1=11 cycles.
//  data_valid in START/DATA/PARITY is ignored; the word is dropped, with no queueing and no error.
//  Changes to p_data/par_en/par_typ after accept do not affect the frame in flight.
//  Illegal state encoding -> IDLE on the next edge, tx_out=1.
//  Bit counter is ceil(log2(DATA_WIDTH)) bits wide, clears on accept, and never wraps mid-frame.
// STRUCTURE
//  Package uart_pkg: tx state typedef (IDLE,START,DATA,PARITY,STOP), PAR_EVEN=1'b0,
//   PAR_ODD=1'b1, LINE_IDLE=1'b1, START_BIT=1'b0, STOP_BIT=1'b1. Shared with the RX side.
//  Top-level uart_tx: FSM, parity calculator and output mux/register.
//  Sub-module uart_tx_serializer: load/shift register plus bit counter, with outputs
//   ser_bit and ser_done.
// TESTING
//  1 p_data=0xA5, par_en=1, par_typ=0, one valid pulse -> tx_out 0,1,0,1,0,0,1,0,1,0,1 (11 cyc);
//    busy high for exactly 11 cycles.
//  2 Same with par_typ=1 -> parity cycle=1; with par_en=0 -> 10-cycle frame, no parity bit.
//  3 0x00 then 0xFF back-to-back (valid held through the stop cycle), par_en=0
//    -> 20 contiguous cycles, busy never drops; second frame starts right after the stop bit.
//  4 valid pulse with p_data=0x3C during DATA of a 0x81 frame -> 0x81 sent intact; 0x3C dropped;
//    IDLE afterwards.
//  5 Assert reset_n=0 in DATA bit 4 -> tx_out=1 and busy=0 immediately (async);
//    after release, idle until next valid.
//  6 Random p_data/par_en/par_typ, 1000 frames -> scoreboard decode matches; parity bit per rule.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the TX and RX sides: state type and line-level constants.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;
  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_tx_serializer.sv
// Load/shift register plus bit counter for the TX payload; ser_bit_o is the next bit to emit.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  shift_i,
  input  logic                  count_i,
  output logic                  ser_bit_o,
  output logic                  ser_done_o
);

  localparam int unsigned CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (load_i) begin
      shift_d = data_i;
      cnt_d   = '0;
    end else begin
      if (shift_i) shift_d = shift_q >> 1;
      // saturate at the last index so the counter can never wrap inside a frame
      if (count_i && (cnt_q != LAST)) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ser_bit_o  = shift_q[0];
  assign ser_done_o = (cnt_q == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one serial bit per clk, frame = start, data LSB-first, optional parity, stop.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic                  tx_out,
  output logic                  busy
);

  tx_state_e state_q, state_d;
  logic      tx_out_q, tx_out_d;
  logic      busy_q, busy_d;
  logic      par_en_q, par_en_d;
  logic      par_bit_q, par_bit_d;
  logic      accept, load, shift, count;
  logic      ser_bit, ser_done;

  uart_tx_serializer #(.DATA_WIDTH(DATA_WIDTH)) u_ser (
    .clk       (clk),
    .reset_n   (reset_n),
    .load_i    (load),
    .data_i    (p_data),
    .shift_i   (shift),
    .count_i   (count),
    .ser_bit_o (ser_bit),
    .ser_done_o(ser_done)
  );

  // Outputs are registered, so each branch computes the bit the *next* state will show.
  always_comb begin
    state_d   = state_q;
    tx_out_d  = LINE_IDLE;
    busy_d    = 1'b1;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    accept    = 1'b0;
    load      = 1'b0;
    shift     = 1'b0;
    count     = 1'b0;

    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        accept = data_valid;
      end
      START: begin
        state_d  = DATA;
        tx_out_d = ser_bit;
        shift    = 1'b1;
      end
      DATA: begin
        if (ser_done) begin
          if (par_en_q) begin
            state_d  = PARITY;
            tx_out_d = par_bit_q;
          end else begin
            state_d  = STOP;
            tx_out_d = STOP_BIT;
          end
        end else begin
          tx_out_d = ser_bit;
          shift    = 1'b1;
          count    = 1'b1;
        end
      end
      PARITY: begin
        state_d  = STOP;
        tx_out_d = STOP_BIT;
      end
      STOP: begin
        if (data_valid) begin
          accept = 1'b1;
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase

    if (accept) begin
      state_d   = START;
      tx_out_d  = START_BIT;
      busy_d    = 1'b1;
      load      = 1'b1;
      par_en_d  = par_en;
      par_bit_d = (^p_data) ^ (par_typ == PAR_ODD);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      tx_out_q  <= LINE_IDLE;
      busy_q    <= 1'b0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_out_q  <= tx_out_d;
      busy_q    <= busy_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
    end
  end

  assign tx_out = tx_out_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: frame-level reference model, per-cycle compare, directed literal checks, random frames.
module tb_uart_tx;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic [DW-1:0] p_data = '0;
  logic          data_valid = 1'b0;
  logic          par_en = 1'b0;
  logic          par_typ = 1'b0;
  logic          tx_out;
  logic          busy;

  int total = 0;
  int bad = 0;

  uart_tx #(.DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .p_data    (p_data),
    .data_valid(data_valid),
    .par_en    (par_en),
    .par_typ   (par_typ),
    .tx_out    (tx_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Reference model: a frame is a list of line bits; a new word is taken only when nothing
  // remains queued after the bit currently on the line (idle, or showing the stop bit).
  logic exp_q[$];
  logic m_tx = 1'b1;
  logic m_busy = 1'b0;
  int   frames = 0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      exp_q.delete();
      m_tx   = 1'b1;
      m_busy = 1'b0;
    end else if (exp_q.size() == 0 && data_valid) begin
      m_tx   = 1'b0;
      m_busy = 1'b1;
      for (int i = 0; i < DW; i++) exp_q.push_back(p_data[i]);
      if (par_en) exp_q.push_back(logic'(($countones(p_data) % 2) != 0) ^ par_typ);
      exp_q.push_back(1'b1);
      frames++;
    end else if (exp_q.size() != 0) begin
      m_tx   = exp_q.pop_front();
      m_busy = 1'b1;
    end else begin
      m_tx   = 1'b1;
      m_busy = 1'b0;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Starts one frame from idle and samples tx_out/busy for n+2 cycles; optional stray valid pulse.
  task automatic run_frame(input logic [DW-1:0] d, input logic pe, input logic pt, input int n,
                           input int stray_at, output logic [31:0] bits, output int bcnt);
    bits = '0;
    bcnt = 0;
    p_data = d; par_en = pe; par_typ = pt; data_valid = 1'b1;
    for (int i = 0; i < n + 2; i++) begin
      @(negedge clk);
      if (i < n) bits[i] = tx_out;
      bcnt += int'(busy);
      #1;
      if (i == 0) begin
        data_valid = 1'b0;
        p_data = ~d; par_en = ~pe; par_typ = ~pt;
      end
      if (i == stray_at) begin
        data_valid = 1'b1;
        p_data = 8'h3C;
      end
      if (i == stray_at + 1) data_valid = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] bits;
    int          bcnt;
    int          target;

    fork
      forever begin
        @(negedge clk);
        total++;
        if (tx_out !== m_tx || busy !== m_busy) begin
          bad++;
          $display("FAIL cycle t=%0t: tx_out=%b busy=%b expected tx_out=%b busy=%b",
                   $time, tx_out, busy, m_tx, m_busy);
        end
      end
    join_none

    #1 reset_n = 1'b0;
    #1;
    check("reset tx_out", {31'd0, tx_out}, 32'd1);
    check("reset busy", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    #1 reset_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;

    // 0xA5 8E1
    run_frame(8'hA5, 1'b1, 1'b0, 11, -10, bits, bcnt);
    check("A5 even bits", bits, 32'b10101001010);
    check("A5 even busy", bcnt, 11);
    // 0xA5 8O1: parity cycle flips
    run_frame(8'hA5, 1'b1, 1'b1, 11, -10, bits, bcnt);
    check("A5 odd bits", bits, 32'b11101001010);
    check("A5 odd parity", {31'd0, bits[9]}, 32'd1);
    // 0xA5 8N1
    run_frame(8'hA5, 1'b0, 1'b0, 10, -10, bits, bcnt);
    check("A5 none bits", bits, 32'b1101001010);
    check("A5 none busy", bcnt, 10);

    // back-to-back 0x00 then 0xFF with valid held through the stop cycle
    p_data = 8'h00; par_en = 1'b0; par_typ = 1'b0; data_valid = 1'b1;
    bits = '0; bcnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bits[i] = tx_out;
      bcnt += int'(busy);
      #1;
      if (i == 0) p_data = 8'hFF;
      if (i == 10) data_valid = 1'b0;
    end
    check("b2b bits", bits, 32'hFFA00);
    check("b2b busy", bcnt, 20);
    repeat (2) @(negedge clk);
    check("b2b idle after", {30'd0, busy, tx_out}, 32'd1);
    #1;

    // stray valid during DATA of 0x81 is dropped
    run_frame(8'h81, 1'b0, 1'b0, 10, 4, bits, bcnt);
    check("81 intact bits", bits, 32'b1100000010);
    check("81 busy", bcnt, 10);
    repeat (3) @(negedge clk);
    check("81 idle after", {30'd0, busy, tx_out}, 32'd1);
    #1;

    // async reset in DATA bit 4
    p_data = 8'h5A; par_en = 1'b0; data_valid = 1'b1;
    @(negedge clk);
    #1 data_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("pre-reset busy", {31'd0, busy}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("async reset tx_out", {31'd0, tx_out}, 32'd1);
    check("async reset busy", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    #1 reset_n = 1'b1;
    repeat (4) @(negedge clk);
    check("post-reset idle", {30'd0, busy, tx_out}, 32'd1);
    #1;
    run_frame(8'hA5, 1'b0, 1'b0, 10, -10, bits, bcnt);
    check("post-reset frame", bits, 32'b1101001010);

    // random frames, random back-to-back and stray strobes
    target = frames + 1000;
    for (int c = 0; c < 40000 && frames < target; c++) begin
      @(negedge clk);
      #1;
      data_valid = ($urandom_range(0, 2) != 0);
      p_data     = DW'($urandom);
      par_en     = 1'($urandom);
      par_typ    = 1'($urandom);
    end
    data_valid = 1'b0;
    check("random frame count reached", {31'd0, frames >= target}, 32'd1);
    repeat (14) @(negedge clk);
    check("final idle", {30'd0, busy, tx_out}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
